// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 offset field modes and widths
package lc3_pkg;

  typedef enum logic [1:0] {
    IMM5  = 2'd0,
    OFF6  = 2'd1,
    OFF9  = 2'd2,
    OFF11 = 2'd3
  } mode_e;

  localparam int W_IMM5  = 5;
  localparam int W_OFF6  = 6;
  localparam int W_OFF9  = 9;
  localparam int W_OFF11 = 11;

  localparam int VAL_W   = 16;
  localparam int FIELD_W = 11;
  localparam int ERR_W   = 8;

endpackage

// File: rtl/field_fit.sv
// rtl/field_fit.sv - signed range check and truncation of a 16-bit value to a mode field
module field_fit
  import lc3_pkg::*;
(
  input  logic [VAL_W-1:0]   value,
  input  logic [1:0]         mode,
  output logic [FIELD_W-1:0] field,
  output logic               fits
);

  mode_e w_mode;
  assign w_mode = mode_e'(mode);

  // A value fits when every bit from the field's sign bit upward is identical.
  always_comb begin
    field = '0;
    fits  = 1'b0;
    case (w_mode)
      IMM5: begin
        field = {{(FIELD_W-W_IMM5){1'b0}}, value[W_IMM5-1:0]};
        fits  = (&value[VAL_W-1:W_IMM5-1]) | ~(|value[VAL_W-1:W_IMM5-1]);
      end
      OFF6: begin
        field = {{(FIELD_W-W_OFF6){1'b0}}, value[W_OFF6-1:0]};
        fits  = (&value[VAL_W-1:W_OFF6-1]) | ~(|value[VAL_W-1:W_OFF6-1]);
      end
      OFF9: begin
        field = {{(FIELD_W-W_OFF9){1'b0}}, value[W_OFF9-1:0]};
        fits  = (&value[VAL_W-1:W_OFF9-1]) | ~(|value[VAL_W-1:W_OFF9-1]);
      end
      OFF11: begin
        field = value[W_OFF11-1:0];
        fits  = (&value[VAL_W-1:W_OFF11-1]) | ~(|value[VAL_W-1:W_OFF11-1]);
      end
      default: begin
        field = '0;
        fits  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/offset_pack.sv
// rtl/offset_pack.sv - two-stage pipeline packing immediates/PC-relative offsets into LC-3 fields
module offset_pack
  import lc3_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic                in_rel,
  input  logic [VAL_W-1:0]    in_pc,
  input  logic [VAL_W-1:0]    in_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FIELD_W-1:0]  out_field,
  output logic                out_fits,
  output logic [1:0]          out_mode,
  input  logic                err_clr,
  output logic [ERR_W-1:0]    err_count
);

  logic               r_s1_valid;
  logic [VAL_W-1:0]   r_s1_val;
  logic [1:0]         r_s1_mode;
  logic               r_s2_valid;
  logic [FIELD_W-1:0] r_s2_field;
  logic               r_s2_fits;
  logic [1:0]         r_s2_mode;
  logic [ERR_W-1:0]   r_err_count;

  logic               w_adv;
  logic               w_in_ready;
  logic [VAL_W-1:0]   w_in_value;
  logic [FIELD_W-1:0] w_fit_field;
  logic               w_fit_fits;

  // S2 may accept whenever it is empty or draining; S1 may accept whenever it is empty or moving on.
  assign w_adv      = !r_s2_valid || out_ready;
  assign w_in_ready = w_adv || !r_s1_valid;
  assign w_in_value = in_rel ? (in_val - (in_pc + 16'd1)) : in_val;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_val   <= '0;
      r_s1_mode  <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_val  <= w_in_value;
        r_s1_mode <= in_mode;
      end
    end
  end

  field_fit u_field_fit (
    .value (r_s1_val),
    .mode  (r_s1_mode),
    .field (w_fit_field),
    .fits  (w_fit_fits)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s2_valid <= 1'b0;
      r_s2_field <= '0;
      r_s2_fits  <= 1'b0;
      r_s2_mode  <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_field <= w_fit_field;
        r_s2_fits  <= w_fit_fits;
        r_s2_mode  <= r_s1_mode;
      end
    end
  end

  // Clear wins over a same-cycle miss so software never reads a stale count after clearing.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (r_s2_valid && out_ready && !r_s2_fits && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_field = r_s2_field;
  assign out_fits  = r_s2_fits;
  assign out_mode  = r_s2_mode;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_offset_pack.sv
// tb/tb_offset_pack.sv - scoreboard bench for offset_pack
module tb_offset_pack;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic        in_rel;
  logic [15:0] in_pc;
  logic [15:0] in_val;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_field;
  logic        out_fits;
  logic [1:0]  out_mode;
  logic        err_clr;
  logic [7:0]  err_count;

  offset_pack dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_rel    (in_rel),
    .in_pc     (in_pc),
    .in_val    (in_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_fits  (out_fits),
    .out_mode  (out_mode),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic        fits;
    logic [10:0] field;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_err = 0;
  logic [10:0] exp_field;
  logic        exp_fits;
  logic        rand_bp = 1'b0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_out;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void model(input logic [1:0] m, input logic r, input logic [15:0] pc,
                                input logic [15:0] val, output logic [10:0] f, output logic fit);
    logic [15:0] v;
    int w;
    int sv;
    v   = r ? (val - (pc + 16'd1)) : val;
    w   = (m == 2'd0) ? 5 : (m == 2'd1) ? 6 : (m == 2'd2) ? 9 : 11;
    sv  = int'($signed(v));
    fit = (sv >= -(1 << (w - 1))) && (sv <= (1 << (w - 1)) - 1);
    f   = 11'(int'(v) & ((1 << w) - 1));
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer, model err_count.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      sb.delete();
      m_err = 0;
      prev_stall = 1'b0;
    end
    check("err_count", {24'd0, err_count}, m_err);
    if (!Reset) begin
      if (prev_stall)
        check("stall_hold", {17'd0, out_valid, out_mode, out_fits, out_field}, {17'd0, 1'b1, prev_out});
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_mode, out_fits, out_field};
      if (in_valid && in_ready)
        sb.push_back({in_mode, exp_fits, exp_field});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_field", {21'd0, out_field}, {21'd0, e.field});
          check("out_fits", {31'd0, out_fits}, {31'd0, e.fits});
          check("out_mode", {30'd0, out_mode}, {30'd0, e.mode});
          if (!err_clr && !e.fits && m_err < 255) m_err = m_err + 1;
        end
      end
      if (err_clr) m_err = 0;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [1:0] m, input logic r, input logic [15:0] pc, input logic [15:0] val,
                      input logic [10:0] ef, input logic efit, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    in_valid = 1'b1; in_mode = m; in_rel = r; in_pc = pc; in_val = val;
    exp_field = ef; exp_fits = efit;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge Clk);
      acc = in_ready;
      if (!acc) stalls++;
      tick();
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [1:0] m, input logic r, input logic [15:0] pc, input logic [15:0] val,
                        output int stalls);
    logic [10:0] f;
    logic fit;
    model(m, r, pc, val, f, fit);
    send(m, r, pc, val, f, fit, stalls);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge Clk);
      done = (sb.size() == 0) && !out_valid;
      if (!done) tick();
    end
    if (!done) check("drain_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int st;
    int tot;
    int acc_n;
    int idx;
    logic [15:0] bp_val [3];
    logic [13:0] held;
    logic got;

    Reset = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_rel = 1'b0; in_pc = 16'd0; in_val = 16'd0;
    out_ready = 1'b0; err_clr = 1'b0; exp_field = '0; exp_fits = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_field", {21'd0, out_field}, 0);
    check("rst_fits_mode", {29'd0, out_fits, out_mode}, 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    tick();
    out_ready = 1'b1;

    send(2'd0, 1'b0, 16'h0000, 16'hFFF0, 11'h010, 1'b1, st);
    send(2'd0, 1'b0, 16'h0000, 16'h0010, 11'h010, 1'b0, st);
    wait_idle();
    check("imm5_err", {24'd0, err_count}, 1);

    send(2'd2, 1'b1, 16'h3000, 16'h3100, 11'h0FF, 1'b1, st);
    send(2'd2, 1'b1, 16'h3000, 16'h3101, 11'h100, 1'b0, st);
    send(2'd2, 1'b1, 16'h3000, 16'h2F01, 11'h100, 1'b1, st);
    send(2'd3, 1'b1, 16'hFFFF, 16'h0000, 11'h000, 1'b1, st);
    wait_idle();

    send(2'd0, 1'b0, 16'h0000, 16'h0003, 11'h003, 1'b1, st);
    @(negedge Clk);
    check("lat_cycle1", {31'd0, out_valid}, 0);
    tick();
    @(negedge Clk);
    check("lat_cycle2", {31'd0, out_valid}, 1);
    tick();
    wait_idle();

    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send_m(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), st);
      tot += st;
    end
    check("throughput_stalls", tot, 0);
    wait_idle();

    bp_val[0] = 16'h0005; bp_val[1] = 16'h0020; bp_val[2] = 16'hFFE0;
    out_ready = 1'b0;
    acc_n = 0;
    idx = 0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_mode = 2'd1; in_rel = 1'b0; in_pc = 16'd0; in_val = bp_val[idx];
      model(2'd1, 1'b0, 16'd0, bp_val[idx], exp_field, exp_fits);
      @(negedge Clk);
      if (in_ready) begin
        acc_n++;
        idx++;
      end
      if (c == 2) held = {out_mode, out_fits, out_field};
      tick();
    end
    @(negedge Clk);
    check("bp_accepted", acc_n, 2);
    check("bp_in_ready", {31'd0, in_ready}, 0);
    check("bp_hold", {18'd0, out_mode, out_fits, out_field}, {18'd0, held});
    tick();
    out_ready = 1'b1;
    in_valid = 1'b0;
    send_m(2'd1, 1'b0, 16'd0, bp_val[2], st);
    wait_idle();

    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_m(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(0, 65535)), st);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    for (int i = 0; i < 260; i++) send(2'd0, 1'b0, 16'd0, 16'h0010, 11'h010, 1'b0, st);
    wait_idle();
    check("err_saturate", {24'd0, err_count}, 255);

    out_ready = 1'b0;
    send(2'd0, 1'b0, 16'd0, 16'h0010, 11'h010, 1'b0, st);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      got = out_valid;
      tick();
    end
    check("clr_wait_valid", {31'd0, got}, 1);
    out_ready = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge Clk);
    check("err_clr_priority", {24'd0, err_count}, 0);
    tick();
    wait_idle();

    out_ready = 1'b0;
    send(2'd0, 1'b0, 16'd0, 16'h0001, 11'h001, 1'b1, st);
    send(2'd0, 1'b0, 16'd0, 16'h0002, 11'h002, 1'b1, st);
    check("rst_pre_valid", {31'd0, out_valid}, 1);
    Reset = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 0);
    tick();
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_release_ready", {31'd0, in_ready}, 1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("rst_no_delivery", {31'd0, out_valid}, 0);
      tick();
    end
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
